// File: rtl/_shift_unit_en.sv
// Clock-enabled shift/rotate register with a multi-cycle IDLE/SHIFT/DONE sequencer.
// A shift command latches its mode and step count; each enabled SHIFT cycle performs one step.
module _shift_unit_en #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AMT_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [AMT_W-1:0] amt,
  input  logic [WIDTH-1:0] d,
  input  logic             si,
  output logic [WIDTH-1:0] q,
  output logic             so,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StShift = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  localparam logic [2:0] ModeHold = 3'b000;
  localparam logic [2:0] ModeLoad = 3'b001;
  localparam logic [2:0] ModeShl  = 3'b010;
  localparam logic [2:0] ModeShr  = 3'b011;
  localparam logic [2:0] ModeRol  = 3'b100;
  localparam logic [2:0] ModeRor  = 3'b101;
  localparam logic [2:0] ModeAsr  = 3'b110;
  localparam logic [2:0] ModeClr  = 3'b111;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             so_q, so_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;

  logic [WIDTH-1:0] step_q;
  logic             step_so;

  // One single-bit step of the latched operation; si is sampled live each step.
  always_comb begin
    step_q  = q_q;
    step_so = so_q;
    case (op_q)
      ModeShl: begin
        step_q  = {q_q[WIDTH-2:0], si};
        step_so = q_q[WIDTH-1];
      end
      ModeShr: begin
        step_q  = {si, q_q[WIDTH-1:1]};
        step_so = q_q[0];
      end
      ModeRol: begin
        step_q  = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        step_so = q_q[WIDTH-1];
      end
      ModeRor: begin
        step_q  = {q_q[0], q_q[WIDTH-1:1]};
        step_so = q_q[0];
      end
      ModeAsr: begin
        step_q  = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
        step_so = q_q[0];
      end
      default: begin
        step_q  = q_q;
        step_so = so_q;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    so_d    = so_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    unique case (state_q)
      StIdle: begin
        if (en) begin
          unique case (mode)
            ModeHold: ;
            ModeLoad: q_d = d;
            ModeClr:  q_d = '0;
            default: begin
              if (start) begin
                op_d    = mode;
                cnt_d   = amt;
                state_d = (amt != '0) ? StShift : StDone;
              end
            end
          endcase
        end
      end
      StShift: begin
        if (en) begin
          q_d   = step_q;
          so_d  = step_so;
          cnt_d = cnt_q - AMT_W'(1);
          if (cnt_q == AMT_W'(1)) state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      q_q     <= '0;
      so_q    <= 1'b0;
      cnt_q   <= '0;
      op_q    <= ModeHold;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      so_q    <= so_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  assign q    = q_q;
  assign so   = so_q;
  assign busy = (state_q == StShift);
  assign done = (state_q == StDone);

endmodule

// File: tb/tb__shift_unit_en.sv
// Self-checking bench for _shift_unit_en: directed scenarios plus randomized traffic
// compared against an arithmetic reference model.
module tb__shift_unit_en;

  logic       clk;
  logic       reset_n;
  logic       en;
  logic       start;
  logic [2:0] mode;
  logic [3:0] amt;
  logic [7:0] d;
  logic       si;
  logic [7:0] q;
  logic       so;
  logic       busy;
  logic       done;

  int checks;
  int failures;

  // Reference model: phase 0 idle, 1 shifting, 2 done.
  int m_q, m_so, m_phase, m_rem, m_op;

  _shift_unit_en #(.WIDTH(8), .AMT_W(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en),
    .start   (start),
    .mode    (mode),
    .amt     (amt),
    .d       (d),
    .si      (si),
    .q       (q),
    .so      (so),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Returns so*256 + new q for one step of op on value qv.
  function automatic int step_val(input int op, input int qv, input int s);
    int nq, nso;
    case (op)
      2: begin nq = ((qv * 2) + s) % 256;           nso = qv / 128; end
      3: begin nq = (qv / 2) + s * 128;             nso = qv % 2;   end
      4: begin nq = ((qv * 2) % 256) + qv / 128;    nso = qv / 128; end
      5: begin nq = (qv / 2) + (qv % 2) * 128;      nso = qv % 2;   end
      default: begin nq = (qv / 2) + (qv / 128) * 128; nso = qv % 2; end
    endcase
    return nso * 256 + nq;
  endfunction

  task automatic model_reset();
    m_q = 0; m_so = 0; m_phase = 0; m_rem = 0; m_op = 0;
  endtask

  task automatic model_edge();
    int r;
    case (m_phase)
      0: if (en) begin
        if (mode == 3'd1) m_q = int'(d);
        else if (mode == 3'd7) m_q = 0;
        else if (mode != 3'd0 && start) begin
          m_op = int'(mode);
          m_rem = int'(amt);
          m_phase = (amt > 0) ? 1 : 2;
        end
      end
      1: if (en) begin
        r = step_val(m_op, m_q, int'(si));
        m_q = r % 256;
        m_so = r / 256;
        m_rem = m_rem - 1;
        if (m_rem == 0) m_phase = 2;
      end
      default: m_phase = 0;
    endcase
  endtask

  // Advance one clock edge; outputs are stable #1 afterwards.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic e, input logic st, input logic [2:0] m, input logic [3:0] a,
                       input logic [7:0] dv, input logic s);
    en = e; start = st; mode = m; amt = a; d = dv; si = s;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive(1'b1, 1'b0, 3'd0, 4'd0, 8'h00, 1'b0);
    model_reset();
    #3;
    checks++; if (q !== 8'h00) begin failures++; $display("FAIL rst_init_q got=%h exp=00", q); end
    checks++; if ({so, busy, done} !== 3'b000) begin
      failures++; $display("FAIL rst_init_flags got=%b exp=000", {so, busy, done});
    end
    @(negedge clk);
    reset_n = 1'b1;
    // Mid-SHIFT asynchronous reset.
    drive(1'b1, 1'b0, 3'd1, 4'd0, 8'hA5, 1'b0); tick();
    drive(1'b1, 1'b1, 3'd2, 4'd5, 8'h00, 1'b1); tick();
    tick(); tick();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rst_pre_busy got=%b exp=1", busy); end
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    checks++; if (q !== 8'h00) begin failures++; $display("FAIL rst_mid_q got=%h exp=00", q); end
    checks++; if ({so, busy, done} !== 3'b000) begin
      failures++; $display("FAIL rst_mid_flags got=%b exp=000", {so, busy, done});
    end
    #1;
    reset_n = 1'b1;
    drive(1'b1, 1'b0, 3'd1, 4'd0, 8'h5A, 1'b0); tick();
    checks++; if (q !== 8'h5A) begin failures++; $display("FAIL rst_first_op got=%h exp=5a", q); end
  endtask

  task automatic test_load_en();
    drive(1'b1, 1'b0, 3'd1, 4'd0, 8'hA5, 1'b0); tick();
    checks++; if (q !== 8'hA5) begin failures++; $display("FAIL load_q got=%h exp=a5", q); end
    drive(1'b0, 1'b0, 3'd1, 4'd0, 8'h3C, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (q !== 8'hA5) begin failures++; $display("FAIL load_en0_q got=%h exp=a5", q); end
    end
    drive(1'b1, 1'b0, 3'd7, 4'd0, 8'h00, 1'b0); tick();
    checks++; if (q !== 8'h00) begin failures++; $display("FAIL clr_q got=%h exp=00", q); end
  endtask

  task automatic test_shl();
    logic [7:0] exp_seq [3];
    int nbusy;
    exp_seq[0] = 8'hA5; exp_seq[1] = 8'h4B; exp_seq[2] = 8'h97;
    nbusy = 0;
    drive(1'b1, 1'b0, 3'd1, 4'd0, 8'hA5, 1'b1); tick();
    drive(1'b1, 1'b1, 3'd2, 4'd3, 8'h00, 1'b1); tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (q !== exp_seq[i]) begin
        failures++; $display("FAIL shl_seq%0d got=%h exp=%h", i, q, exp_seq[i]);
      end
      if (busy) nbusy++;
      tick();
    end
    checks++; if (nbusy != 3) begin failures++; $display("FAIL shl_busy_cycles got=%0d exp=3", nbusy); end
    checks++; if ({done, busy, so, q} !== {1'b1, 1'b0, 1'b1, 8'h2F}) begin
      failures++; $display("FAIL shl_done got=%b/%b/%b/%h exp=1/0/1/2f", done, busy, so, q);
    end
    tick();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL shl_done_pulse got=%b exp=0", done); end
  endtask

  task automatic test_asr_stall();
    int nbusy;
    nbusy = 0;
    drive(1'b1, 1'b0, 3'd1, 4'd0, 8'h90, 1'b0); tick();
    drive(1'b1, 1'b1, 3'd6, 4'd2, 8'h00, 1'b1); tick();
    if (busy) nbusy++;
    start = 1'b0; tick();
    if (busy) nbusy++;
    checks++; if (q !== 8'hC8) begin failures++; $display("FAIL asr_step1 got=%h exp=c8", q); end
    en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (busy) nbusy++;
      checks++; if (q !== 8'hC8 || busy !== 1'b1) begin
        failures++; $display("FAIL asr_stall q/busy got=%h/%b exp=c8/1", q, busy);
      end
    end
    en = 1'b1; tick();
    checks++; if ({q, so, done} !== {8'hE4, 1'b0, 1'b1}) begin
      failures++; $display("FAIL asr_final got=%h/%b/%b exp=e4/0/1", q, so, done);
    end
    checks++; if (nbusy != 4) begin failures++; $display("FAIL asr_busy_cycles got=%0d exp=4", nbusy); end
    tick();
  endtask

  task automatic test_ror();
    int nbusy;
    nbusy = 0;
    drive(1'b1, 1'b0, 3'd1, 4'd0, 8'h81, 1'b0); tick();
    drive(1'b1, 1'b1, 3'd5, 4'd8, 8'h00, 1'b0); tick();
    start = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (busy) nbusy++;
      tick();
    end
    checks++; if (nbusy != 8) begin failures++; $display("FAIL ror_busy_cycles got=%0d exp=8", nbusy); end
    checks++; if (q !== 8'h81 || done !== 1'b1) begin
      failures++; $display("FAIL ror_final got=%h/%b exp=81/1", q, done);
    end
    tick();
    drive(1'b1, 1'b1, 3'd5, 4'd0, 8'h00, 1'b0); tick();
    start = 1'b0;
    checks++; if ({done, busy, q} !== {1'b1, 1'b0, 8'h81}) begin
      failures++; $display("FAIL ror_amt0 got=%b/%b/%h exp=1/0/81", done, busy, q);
    end
    tick();
  endtask

  task automatic test_busy_ignore();
    drive(1'b1, 1'b0, 3'd1, 4'd0, 8'h01, 1'b0); tick();
    drive(1'b1, 1'b1, 3'd4, 4'd4, 8'h00, 1'b0); tick();
    drive(1'b1, 1'b1, 3'd1, 4'd1, 8'hFF, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (q !== m_q[7:0]) begin
        failures++; $display("FAIL ignore_q step%0d got=%h exp=%h", i, q, m_q[7:0]);
      end
    end
    checks++; if (q !== 8'h10 || done !== 1'b1) begin
      failures++; $display("FAIL ignore_final got=%h/%b exp=10/1", q, done);
    end
    // Command in DONE must be ignored too.
    tick();
    checks++; if (q !== 8'h10) begin failures++; $display("FAIL ignore_done_cmd got=%h exp=10", q); end
    start = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      en    = ($urandom_range(0, 9) < 8);
      start = $urandom_range(0, 1);
      mode  = 3'($urandom_range(0, 7));
      amt   = 4'($urandom_range(0, 15));
      d     = 8'($urandom_range(0, 255));
      si    = $urandom_range(0, 1);
      tick();
      checks++; if (q !== m_q[7:0] || so !== m_so[0]) begin
        failures++; $display("FAIL rand_data cyc=%0d got=%h/%b exp=%h/%b", i, q, so, m_q[7:0], m_so[0]);
      end
      checks++; if (busy !== (m_phase == 1) || done !== (m_phase == 2)) begin
        failures++; $display("FAIL rand_status cyc=%0d got=%b/%b exp_phase=%0d", i, busy, done, m_phase);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_load_en();
    test_shl();
    test_asr_stall();
    test_ror();
    test_busy_ignore();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
